// File: rtl/instr_prefetch.sv
// Instruction fetch front end: one-outstanding req/gnt/rvalid fetch engine feeding
// a small address-tagged FIFO that presents Instr/PC to the datapath.
module instr_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc;
    logic [31:0]    req_pc;
    logic [31:0]    fifo_instr [DEPTH];
    logic [31:0]    fifo_pc    [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  inflight;
    logic           space;
    logic           fire;
    logic           resp;
    logic           push;
    logic           pop;

    // An outstanding request reserves a FIFO slot so its response can never overflow.
    assign inflight = {{(CW-1){1'b0}}, (state_q != IDLE)};
    assign space    = (count_q + inflight) < CW'(DEPTH);

    assign resp     = (state_q == WAIT) && imem_rvalid;
    assign imem_req = !reset && !redirect && space && ((state_q == IDLE) || resp);
    assign fire     = imem_req && imem_gnt;
    assign push     = resp && !redirect;
    assign pop      = instr_valid && instr_ready && !redirect;

    assign imem_addr   = fetch_pc;
    assign instr_valid = (count_q != '0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign count       = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A redirect before the response arrives leaves a word in flight to discard.
                if (redirect) begin
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    state_d = fire ? WAIT : IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            if (push) begin
                fifo_instr[wr_ptr] <= imem_rdata;
                fifo_pc[wr_ptr]    <= req_pc;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule
